// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: PC/IF-ID/ID-EX/EX-MEM/MEM-WB enables, load-use stall, branch flush, mem-wait freeze, timeout fault.
// Latency: all controls are combinational from state + inputs and act in the detection cycle; counters/fault update on next clk.
// Backpressure: mem_req & ~mem_ready freezes the whole pipe until mem_ready; a wait longer than TIMEOUT parks in FAULT until err_clr.
module pipeline_hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             err_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_FAULT    = 2'd2;

  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [TO_W-1:0] wait_cnt;
  logic [TO_W-1:0] wait_cnt_nxt;
  logic            mem_fault_nxt;
  logic            stall_inc;
  logic            flush_inc;
  logic            mem_stall;
  logic            lu;
  logic            run_eval;
  logic            freeze;
  logic            hold;

  // Hazard terms; x0 is hard-wired zero so a load to it never creates a dependency.
  always_comb begin
    mem_stall = mem_req & ~mem_ready;
    lu = ex_memread & (ex_rd != 5'd0) &
         ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  end

  // Next-state, wait counter, fault flag and counter-increment decisions.
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    mem_fault_nxt = mem_fault;
    run_eval      = 1'b0;
    freeze        = 1'b0;
    hold          = 1'b0;
    case (state)
      S_RUN: begin
        if (mem_stall) begin
          freeze       = 1'b1;
          state_nxt    = S_MEM_WAIT;
          wait_cnt_nxt = TO_W'(1);
        end else begin
          run_eval = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ready) begin
          // Release cycle behaves exactly like RUN without a memory stall.
          run_eval     = 1'b1;
          state_nxt    = S_RUN;
          wait_cnt_nxt = '0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt == TO_LIMIT) begin
            state_nxt     = S_FAULT;
            mem_fault_nxt = 1'b1;
            wait_cnt_nxt  = '0;
          end else begin
            wait_cnt_nxt = wait_cnt + TO_W'(1);
          end
        end
      end
      S_FAULT: begin
        hold = 1'b1;
        if (err_clr) begin
          state_nxt     = S_RUN;
          mem_fault_nxt = 1'b0;
        end
      end
      default: begin
        hold      = 1'b1;
        state_nxt = S_RUN;
      end
    endcase
    // A frozen cycle is a stall cycle; a load-use bubble only counts when not overridden by a branch.
    stall_inc = freeze | (run_eval & ~ex_br_taken & lu);
    flush_inc = run_eval & ex_br_taken;
  end

  // Pipeline register controls; reset forces the safe "nothing moves, bubbles in" pattern.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    if (rst || hold) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (freeze) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (run_eval && ex_br_taken) begin
      // Wrong-path instructions in IF/ID and ID are squashed; any hazard they raise is moot.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (run_eval && lu) begin
      // Hold PC and IF/ID, insert one bubble so the load reaches MEM before the consumer reads.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // State, wait counter and sticky fault; rst aborts any wait immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RUN;
      wait_cnt  <= '0;
      mem_fault <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mem_fault <= mem_fault_nxt;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_inc && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Latency: model predicts same-cycle controls and next-cycle counters/fault.
// Backpressure: mem_ready is randomly withheld, including long droughts that reach the timeout.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W   = 6;
  localparam int TIMEOUT = 16;
  localparam int CMAX    = (1 << CNT_W) - 1;

  // Control vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble}
  localparam logic [6:0] C_NORM   = 7'b1101010;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_BRANCH = 7'b1111110;
  localparam logic [6:0] C_LU     = 7'b0001110;
  localparam logic [6:0] C_HOLD   = 7'b0000101;

  logic             clk;
  logic             rst;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             ex_br_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             err_clr;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_bubble;
  logic             exmem_en;
  logic             memwb_bubble;
  logic             mem_fault;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .err_clr(err_clr),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_bubble(memwb_bubble),
    .mem_fault(mem_fault), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = running, 1 = waiting on memory, 2 = faulted
  int m_mode   = 0;
  int m_waited = 0;   // consecutive frozen cycles of the current memory wait
  int m_stall  = 0;
  int m_flush  = 0;
  bit m_fault  = 1'b0;
  logic [6:0] exp_ctl;

  function automatic bit hazard();
    bit dep1 = id_use_rs1 && (id_rs1 == ex_rd);
    bit dep2 = id_use_rs2 && (id_rs2 == ex_rd);
    return ex_memread && (ex_rd != 0) && (dep1 || dep2);
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Effect of a normally-advancing cycle on controls and counters.
  task automatic run_cycle(output logic [6:0] ctl);
    if (ex_br_taken) begin
      ctl = C_BRANCH;
      m_flush = sat(m_flush);
    end else if (hazard()) begin
      ctl = C_LU;
      m_stall = sat(m_stall);
    end else begin
      ctl = C_NORM;
    end
  endtask

  // Single compare process: check this cycle's outputs, then advance the model across the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_fault = 1'b0;
      exp_ctl = C_HOLD;
    end
    chk("cnt_stall", 32'(stall_cnt), 32'(m_stall));
    chk("cnt_flush", 32'(flush_cnt), 32'(m_flush));
    chk("fault", 32'(mem_fault), 32'(m_fault));
    if (!rst) begin
      if (m_mode == 2) begin
        exp_ctl = C_HOLD;
        if (err_clr) begin
          m_mode = 0;
          m_fault = 1'b0;
        end
      end else if (m_mode == 1 && mem_ready) begin
        m_mode = 0;
        m_waited = 0;
        run_cycle(exp_ctl);
      end else if (m_mode == 1 || (mem_req && !mem_ready)) begin
        exp_ctl = C_FREEZE;
        m_stall = sat(m_stall);
        if (m_mode == 1 && m_waited >= TIMEOUT) begin
          m_mode = 2;
          m_fault = 1'b1;
          m_waited = 0;
        end else begin
          m_mode = 1;
          m_waited = m_waited + 1;
        end
      end else begin
        run_cycle(exp_ctl);
      end
    end
    chk("ctl", 32'({pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble}),
        32'(exp_ctl));
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_memread = 1'b0; ex_rd = 5'd0; ex_br_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; err_clr = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    nxt(); rst = 1'b1; idle();
    nxt(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    settle();
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_idex_bubble", 32'(idex_bubble), 32'd1);
    chk("rst_memwb_bubble", 32'(memwb_bubble), 32'd1);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    nxt(); rst = 1'b0;
    settle();
    chk("idle_pc_en", 32'(pc_en), 32'd1);
    chk("idle_idex_bubble", 32'(idex_bubble), 32'd0);

    // Load x5 in EX, consumer reads rs1=5
    nxt(); ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    settle();
    chk("lu_pc_en", 32'(pc_en), 32'd0);
    chk("lu_idex_bubble", 32'(idex_bubble), 32'd1);
    chk("lu_exmem_en", 32'(exmem_en), 32'd1);
    nxt(); idle();
    settle();
    chk("lu_one_cycle", 32'(pc_en), 32'd1);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // Load to x0 never stalls
    do_reset();
    nxt(); ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    settle();
    chk("x0_pc_en", 32'(pc_en), 32'd1);
    nxt(); idle();
    settle();
    chk("x0_stall_cnt", 32'(stall_cnt), 32'd0);

    // Taken branch wins over a simultaneous load-use
    nxt(); ex_br_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    settle();
    chk("br_ifid_flush", 32'(ifid_flush), 32'd1);
    chk("br_idex_bubble", 32'(idex_bubble), 32'd1);
    chk("br_pc_en", 32'(pc_en), 32'd1);
    nxt(); idle();
    settle();
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(stall_cnt), 32'd0);

    // Memory busy three cycles, then ready
    do_reset();
    nxt(); mem_req = 1'b1; mem_ready = 1'b0;
    settle();
    chk("mw_c1_pc_en", 32'(pc_en), 32'd0);
    chk("mw_c1_memwb_bubble", 32'(memwb_bubble), 32'd1);
    repeat (2) begin
      nxt(); settle();
      chk("mw_frozen_exmem_en", 32'(exmem_en), 32'd0);
    end
    nxt(); mem_ready = 1'b1;
    settle();
    chk("mw_release_pc_en", 32'(pc_en), 32'd1);
    nxt(); idle();
    settle();
    chk("mw_stall_cnt", 32'(stall_cnt), 32'd3);

    // Memory never ready: fault after TIMEOUT+1 frozen cycles
    do_reset();
    nxt(); mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 1; i <= TIMEOUT + 1; i++) begin
      if (i > 1) nxt();
      settle();
      chk("to_frozen_pc_en", 32'(pc_en), 32'd0);
      chk("to_no_fault_yet", 32'(mem_fault), 32'd0);
    end
    nxt(); idle();
    settle();
    chk("to_fault", 32'(mem_fault), 32'd1);
    chk("to_stall_cnt", 32'(stall_cnt), 32'd17);
    chk("to_fault_idex_bubble", 32'(idex_bubble), 32'd1);
    nxt(); err_clr = 1'b1;
    settle();
    chk("to_clr_cycle_fault", 32'(mem_fault), 32'd1);
    nxt(); idle();
    settle();
    chk("to_cleared_fault", 32'(mem_fault), 32'd0);
    chk("to_cleared_pc_en", 32'(pc_en), 32'd1);

    // Asynchronous reset in the middle of a memory wait
    nxt(); mem_req = 1'b1; mem_ready = 1'b0;
    nxt();
    #1 rst = 1'b1;
    #1;
    chk("arst_idex_bubble", 32'(idex_bubble), 32'd1);
    chk("arst_memwb_bubble", 32'(memwb_bubble), 32'd1);
    chk("arst_pc_en", 32'(pc_en), 32'd0);
    chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    nxt(); rst = 1'b0; idle();
    settle();
    chk("arst_run_pc_en", 32'(pc_en), 32'd1);

    // Saturation: four timeout episodes of 17 stall cycles each exceed 63
    repeat (4) begin
      nxt(); mem_req = 1'b1; mem_ready = 1'b0;
      repeat (TIMEOUT) nxt();
      nxt(); idle(); err_clr = 1'b1;
    end
    nxt(); idle();
    settle();
    chk("sat_stall_cnt", 32'(stall_cnt), 32'(CMAX));

    // Randomized traffic; phases alternate between responsive and sluggish memory
    for (int i = 0; i < 4000; i++) begin
      int thr;
      thr = ((i / 500) % 2 == 0) ? 5 : 1;
      nxt();
      rst         = ($urandom_range(0, 299) == 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_memread  = 1'($urandom_range(0, 1));
      ex_rd       = 5'($urandom_range(0, 3));
      ex_br_taken = ($urandom_range(0, 99) < 15);
      mem_req     = ($urandom_range(0, 99) < 25);
      mem_ready   = ($urandom_range(0, 9) < thr);
      err_clr     = ($urandom_range(0, 9) < 2);
    end
    nxt(); idle(); rst = 1'b0;
    settle();
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
